sram_async_ctrl: RTL and testbench
==================================

// Module: sram_async_ctrl
// PURPOSE
//  Parametrised controller for an external asynchronous SRAM (BlackIce2-style 16-bit SRAM with byte lanes).
//  Converts a single-request req/ready/ack host port into timed CS/OE/WE/byte-lane strobes with programmable
//  wait states and read-to-write bus turnaround. Drives the board top's SB_IO data pins through
//  separate din/dout/drive signals. Sits between sys-level memory arbitration and the top-level pads.
// PARAMETERS
//  ADDR_W    18  SRAM word address width
//  DATA_W    16  data width; multiple of 8; byte lanes BE_W = DATA_W/8
//  RD_WAIT   1   extra cycles OE held before read data is sampled (0..15)
//  WR_WAIT   1   extra cycles WE pulse is held low (0..15)
//  TURN_CYC  1   idle cycles after a read before the next access may be accepted (0..3)
// PORTS
//  clk         in   1       system clock (PLL output)
//  reset_n     in   1       asynchronous reset, active low
//  req         in   1       access request; accepted on an edge where req && ready
//  we          in   1       1 = write, 0 = read; sampled at accept
//  addr        in   ADDR_W  word address; sampled at accept
//  wdata       in   DATA_W  write data; sampled at accept
//  be          in   BE_W    byte enables for write, active high; sampled at accept
//  ready       out  1       controller can accept a request this cycle
//  ack         out  1       one-cycle pulse: access complete
//  rdata       out  DATA_W  read data; valid while ack is high after a read, held until the next read
//  ram_cs_n    out  1       SRAM chip select
//  ram_oe_n    out  1       SRAM output enable
//  ram_we_n    out  1       SRAM write enable
//  ram_be_n    out  BE_W    byte lane selects (lane 0 = LB, lane 1 = UB)
//  ram_adr     out  ADDR_W  SRAM address
//  ram_din     in   DATA_W  data from pads
//  ram_dout    out  DATA_W  data to pads
//  ram_drive   out  1       pad output enable
// BEHAVIOUR
//  - All outputs are registered. Reset values: ready=1, ack=0, rdata=0, cs_n=oe_n=we_n=1, be_n=all 1, adr=0, dout=0, drive=0.
//  - Reset is asynchronous: it forces these values immediately, aborts any access in flight, and no ack is produced.
//  - FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN. A 4-bit counter cnt times the wait states.
//  - IDLE: ready=1. On req&&ready latch addr/be/wdata, set cs_n=0, ready=0.
//    - If we=0: oe_n=0, be_n=all 0, cnt=RD_WAIT, go to RD.
//    - If we=1: be_n=~be, dout=wdata, drive=1, go to WR_SETUP.
//  - RD: if cnt!=0, decrement cnt. If cnt==0, rdata<=ram_din, ack=1, cs_n=oe_n=1.
//    Then go to TURN if TURN_CYC>0, otherwise to IDLE with ready=1.
//  - Read latency: ack goes high RD_WAIT+1 cycles after the accept edge.
//  - WR_SETUP (1 cycle): we_n=0, cnt=WR_WAIT, go to WR_PULSE.
//  - WR_PULSE: if cnt!=0, decrement cnt. If cnt==0, we_n=1, go to WR_HOLD. Address, data and drive stay stable.
//  - WR_HOLD (1 cycle): cs_n=1, drive=0, be_n=all 1, ack=1, ready=1, go to IDLE.
//  - Write occupancy: ack is WR_WAIT+3 cycles after the accept edge.
//  - TURN: hold ready=0 for TURN_CYC cycles with all strobes inactive, then go to IDLE.
//  - Back-to-back: ready is high in the same cycle as ack (except when entering TURN), so a new request is accepted on the next edge.
//  - drive is never 1 while oe_n=0. we_n falls only after address, be_n and dout have been stable for one full cycle.
//  - req while ready=0 is ignored. The requester holds req and its fields until accepted.
//  - Write with be=0: the full cycle runs with be_n all 1 (no byte written). ack still occurs.
//  - Reads always enable all lanes; be is ignored for reads.
//  - ram_adr holds the last address after an access completes (no return to 0).
// TESTING
//  - Reset: assert reset_n=0 mid-write (in WR_PULSE) -> immediately we_n=1, cs_n=1, drive=0, ready=1; no ack follows.
//  - Read, RD_WAIT=1, SRAM model returns 16'hBEEF at 18'h00123 -> ack 2 cycles after accept, rdata=16'hBEEF, oe_n low exactly 2 cycles.
//  - Write, WR_WAIT=1: 16'hA55A to 18'h3FFFF, be=2'b11 -> we_n low 2 cycles, ack 4 cycles after accept, model memory holds A55A.
//  - Byte write: be=2'b10, wdata=16'h12FF over 16'h0000 -> memory=16'h1200; ram_be_n=2'b01 for the whole cycle.
//  - Read immediately followed by write, TURN_CYC=1 -> one cycle with ready=0 and drive=0 between read ack and write accept; no drive/oe overlap.
//  - Random mix of 1000 reads/writes vs a scoreboard, RD_WAIT=0 and WR_WAIT=0 -> all reads match; ack count equals accept count.

Source files
------------

// File: rtl/sram_async_ctrl.sv
// Asynchronous SRAM controller: turns a single-request req/ready/ack host port into
// registered CS/OE/WE/byte-lane strobes with programmable wait states and read turnaround.
module sram_async_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 1,
  parameter int WR_WAIT  = 1,
  parameter int TURN_CYC = 1,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_cs_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [BE_W-1:0]   ram_be_n,
  output logic [ADDR_W-1:0] ram_adr,
  input  logic [DATA_W-1:0] ram_din,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_drive,
  output logic [2:0]        dbg_state
);

  // Host handshake: a request is taken on a rising edge where req && ready; the
  // requester keeps req and its fields stable until then, and ack pulses one cycle
  // when the access is finished.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_TURN     = 3'd5
  } state_t;

  localparam logic [3:0] RD_CNT   = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT   = 4'(WR_WAIT);
  localparam logic [3:0] TURN_CNT = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              ready_nxt, ack_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              cs_n_nxt, oe_n_nxt, we_n_nxt;
  logic [BE_W-1:0]   be_n_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              drive_nxt;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ready     <= 1'b1;
      ack       <= 1'b0;
      rdata     <= '0;
      ram_cs_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_be_n  <= '1;
      ram_adr   <= '0;
      ram_dout  <= '0;
      ram_drive <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready     <= ready_nxt;
      ack       <= ack_nxt;
      rdata     <= rdata_nxt;
      ram_cs_n  <= cs_n_nxt;
      ram_oe_n  <= oe_n_nxt;
      ram_we_n  <= we_n_nxt;
      ram_be_n  <= be_n_nxt;
      ram_adr   <= adr_nxt;
      ram_dout  <= dout_nxt;
      ram_drive <= drive_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = ready;
    ack_nxt   = 1'b0;
    rdata_nxt = rdata;
    cs_n_nxt  = ram_cs_n;
    oe_n_nxt  = ram_oe_n;
    we_n_nxt  = ram_we_n;
    be_n_nxt  = ram_be_n;
    adr_nxt   = ram_adr;
    dout_nxt  = ram_dout;
    drive_nxt = ram_drive;

    case (state)
      S_IDLE: begin
        ready_nxt = 1'b1;
        if (req && ready) begin
          adr_nxt   = addr;
          cs_n_nxt  = 1'b0;
          ready_nxt = 1'b0;
          if (!we) begin
            // Reads always enable both lanes; the pads are never driven.
            oe_n_nxt  = 1'b0;
            be_n_nxt  = '0;
            cnt_nxt   = RD_CNT;
            state_nxt = S_RD;
          end else begin
            be_n_nxt  = ~be;
            dout_nxt  = wdata;
            drive_nxt = 1'b1;
            state_nxt = S_WR_SETUP;
          end
        end
      end

      S_RD: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          rdata_nxt = ram_din;
          ack_nxt   = 1'b1;
          cs_n_nxt  = 1'b1;
          oe_n_nxt  = 1'b1;
          be_n_nxt  = '1;
          if (TURN_CYC > 0) begin
            cnt_nxt   = TURN_CNT;
            ready_nxt = 1'b0;
            state_nxt = S_TURN;
          end else begin
            ready_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end

      // Address, lanes and data were set up on the accept edge, so WE falls one
      // full cycle after they became stable.
      S_WR_SETUP: begin
        we_n_nxt  = 1'b0;
        cnt_nxt   = WR_CNT;
        state_nxt = S_WR_PULSE;
      end

      S_WR_PULSE: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          we_n_nxt  = 1'b1;
          state_nxt = S_WR_HOLD;
        end
      end

      S_WR_HOLD: begin
        cs_n_nxt  = 1'b1;
        drive_nxt = 1'b0;
        be_n_nxt  = '1;
        ack_nxt   = 1'b1;
        ready_nxt = 1'b1;
        state_nxt = S_IDLE;
      end

      // Bus turnaround after a read: SRAM output drivers get time to release.
      S_TURN: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          ready_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        cs_n_nxt  = 1'b1;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        be_n_nxt  = '1;
        drive_nxt = 1'b0;
        ready_nxt = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: instance 0 (RD_WAIT=1, WR_WAIT=1, TURN_CYC=1) runs directed
// cases, instance 1 (all waits 0) runs a random mix; both are checked every cycle against a timing model.
module tb_sram_async_ctrl;

  localparam int RW_P[2] = '{1, 0};
  localparam int WW_P[2] = '{1, 0};
  localparam int TC_P[2] = '{1, 0};

  logic        clk;
  logic        reset_n;
  logic        req [2];
  logic        we [2];
  logic [17:0] addr [2];
  logic [15:0] wdata [2];
  logic [1:0]  be [2];
  logic        ready [2];
  logic        ack [2];
  logic [15:0] rdata [2];
  logic        cs_n [2];
  logic        oe_n [2];
  logic        we_n [2];
  logic [1:0]  be_n [2];
  logic [17:0] adr [2];
  logic [15:0] din [2];
  logic [15:0] dout [2];
  logic        drive [2];
  logic [2:0]  dbg_state [2];

  sram_async_ctrl #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(1), .WR_WAIT(1), .TURN_CYC(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .be(be[0]), .ready(ready[0]), .ack(ack[0]), .rdata(rdata[0]), .ram_cs_n(cs_n[0]),
    .ram_oe_n(oe_n[0]), .ram_we_n(we_n[0]), .ram_be_n(be_n[0]), .ram_adr(adr[0]),
    .ram_din(din[0]), .ram_dout(dout[0]), .ram_drive(drive[0]), .dbg_state(dbg_state[0]));

  sram_async_ctrl #(.ADDR_W(18), .DATA_W(16), .RD_WAIT(0), .WR_WAIT(0), .TURN_CYC(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .be(be[1]), .ready(ready[1]), .ack(ack[1]), .rdata(rdata[1]), .ram_cs_n(cs_n[1]),
    .ram_oe_n(oe_n[1]), .ram_we_n(we_n[1]), .ram_be_n(be_n[1]), .ram_adr(adr[1]),
    .ram_din(din[1]), .ram_dout(dout[1]), .ram_drive(drive[1]), .dbg_state(dbg_state[1]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [15:0] pad_mem [bit [18:0]];
  logic [15:0] ref_mem [bit [18:0]];

  bit          m_act [2];
  int          m_k [2];
  bit          m_w [2];
  logic [1:0]  m_be [2];
  logic [15:0] m_d [2];
  logic [15:0] m_rd [2];
  logic [15:0] last_rdata [2];
  logic [17:0] last_adr [2];
  int          acc_cyc [2];
  int          ack_cyc [2];
  int          acc_cnt [2];
  int          ack_cnt [2];
  int          oe_lo [2];
  int          we_lo [2];
  int          cs_lo [2];
  logic [1:0]  be_or [2];
  logic [1:0]  be_and [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit [18:0] key(input int i, input logic [17:0] a);
    return {i[0], a};
  endfunction

  function automatic logic [15:0] pad_rd(input bit [18:0] k);
    if (pad_mem.exists(k)) return pad_mem[k];
    return 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input bit [18:0] k);
    if (ref_mem.exists(k)) return ref_mem[k];
    return 16'h0000;
  endfunction

  task automatic preload(input int i, input logic [17:0] a, input logic [15:0] d);
    pad_mem[key(i, a)] = d;
    ref_mem[key(i, a)] = d;
  endtask

  // ---------------- behavioural model ----------------
  // Outputs are a function of the transaction kind and k = edges since its accept.
  function automatic bit exp_ready(input int i);
    if (!m_act[i]) return 1'b1;
    if (m_w[i]) return m_k[i] >= WW_P[i] + 3;
    return m_k[i] >= RW_P[i] + 1 + TC_P[i];
  endfunction

  task automatic model_reset(input int i);
    m_act[i] = 1'b0;
    m_k[i] = 0;
    last_rdata[i] = 16'h0000;
    last_adr[i] = 18'h0;
  endtask

  task automatic model_step(input int i);
    logic [15:0] wv;
    if (!reset_n) begin
      model_reset(i);
      return;
    end
    if (req[i] && exp_ready(i)) begin
      m_act[i] = 1'b1;
      m_k[i] = 0;
      m_w[i] = we[i];
      m_be[i] = be[i];
      m_d[i] = wdata[i];
      last_adr[i] = addr[i];
      acc_cyc[i] = cyc;
      acc_cnt[i]++;
      oe_lo[i] = 0; we_lo[i] = 0; cs_lo[i] = 0;
      be_or[i] = 2'b00; be_and[i] = 2'b11;
      if (we[i]) begin
        wv = ref_rd(key(i, addr[i]));
        if (be[i][0]) wv[7:0] = wdata[i][7:0];
        if (be[i][1]) wv[15:8] = wdata[i][15:8];
        ref_mem[key(i, addr[i])] = wv;
      end else begin
        m_rd[i] = ref_rd(key(i, addr[i]));
      end
    end else if (m_act[i] && m_k[i] < 1000) begin
      m_k[i]++;
    end
    if (m_act[i] && !m_w[i] && m_k[i] == RW_P[i] + 1) last_rdata[i] = m_rd[i];
  endtask

  task automatic compare(input int i);
    logic e_cs, e_oe, e_we, e_drv, e_ack;
    logic [1:0] e_be;
    int k;
    if (!reset_n) begin
      model_reset(i);
      chk($sformatf("u%0d.rst_ready", i), ready[i], 1);
      chk($sformatf("u%0d.rst_ack", i), ack[i], 0);
      chk($sformatf("u%0d.rst_rdata", i), rdata[i], 0);
      chk($sformatf("u%0d.rst_strobes", i), {cs_n[i], oe_n[i], we_n[i], be_n[i]}, 5'b11111);
      chk($sformatf("u%0d.rst_adr", i), adr[i], 0);
      chk($sformatf("u%0d.rst_dout", i), dout[i], 0);
      chk($sformatf("u%0d.rst_drive", i), drive[i], 0);
      if (i == 1) chk("rst_state_match", dbg_state[1], dbg_state[0]);
      return;
    end
    e_cs = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_drv = 1'b0; e_ack = 1'b0; e_be = 2'b11;
    k = m_k[i];
    if (m_act[i] && !m_w[i]) begin
      if (k <= RW_P[i]) begin e_cs = 1'b0; e_oe = 1'b0; e_be = 2'b00; end
      if (k == RW_P[i] + 1) e_ack = 1'b1;
    end else if (m_act[i]) begin
      if (k <= WW_P[i] + 2) begin e_cs = 1'b0; e_be = ~m_be[i]; e_drv = 1'b1; end
      if (k >= 1 && k <= WW_P[i] + 1) e_we = 1'b0;
      if (k == WW_P[i] + 3) e_ack = 1'b1;
    end
    chk($sformatf("u%0d.ready", i), ready[i], exp_ready(i));
    chk($sformatf("u%0d.ack", i), ack[i], e_ack);
    chk($sformatf("u%0d.cs_n", i), cs_n[i], e_cs);
    chk($sformatf("u%0d.oe_n", i), oe_n[i], e_oe);
    chk($sformatf("u%0d.we_n", i), we_n[i], e_we);
    chk($sformatf("u%0d.be_n", i), be_n[i], e_be);
    chk($sformatf("u%0d.drive", i), drive[i], e_drv);
    chk($sformatf("u%0d.adr", i), adr[i], last_adr[i]);
    chk($sformatf("u%0d.rdata", i), rdata[i], last_rdata[i]);
    if (e_drv) chk($sformatf("u%0d.dout", i), dout[i], m_d[i]);
    chk($sformatf("u%0d.drive_oe_overlap", i), drive[i] && !oe_n[i], 0);
    if (ack[i]) begin ack_cnt[i]++; ack_cyc[i] = cyc; end
    if (!oe_n[i]) oe_lo[i]++;
    if (!we_n[i]) we_lo[i]++;
    if (!cs_n[i]) begin
      cs_lo[i]++;
      be_or[i] = be_or[i] | be_n[i];
      be_and[i] = be_and[i] & be_n[i];
    end
  endtask

  // Single compare process: model advances on the rising edge, outputs checked on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) compare(i);
    end
  end

  // Asynchronous SRAM pad model: writes while CS and WE are low, drives din while CS and OE are low.
  initial begin
    logic [15:0] wv;
    din[0] = 16'hDEAD;
    din[1] = 16'hDEAD;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!cs_n[i] && !we_n[i]) begin
          wv = pad_rd(key(i, adr[i]));
          if (!be_n[i][0]) wv[7:0] = dout[i][7:0];
          if (!be_n[i][1]) wv[15:8] = dout[i][15:8];
          pad_mem[key(i, adr[i])] = wv;
        end
        din[i] = (!cs_n[i] && !oe_n[i]) ? pad_rd(key(i, adr[i])) : 16'hDEAD;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic issue(input int i, input bit w, input logic [17:0] a,
                       input logic [15:0] d, input logic [1:0] b);
    int n;
    n = 0;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    while (!ready[i] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d.accept_wait", i), ready[i], 1);
    @(negedge clk);
  endtask

  task automatic wait_ack(input int i);
    int n;
    n = 0;
    while (!ack[i] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d.ack_wait", i), ack[i], 1);
    #1;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int saved;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
      acc_cnt[i] = 0; ack_cnt[i] = 0; acc_cyc[i] = 0; ack_cyc[i] = 0;
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", ready[0], 1);
    chk("idle_cs_n", cs_n[0], 1);

    // Read 0x00123 -> BEEF, ack two cycles after accept, OE low two cycles.
    preload(0, 18'h00123, 16'hBEEF);
    issue(0, 1'b0, 18'h00123, 16'h0000, 2'b00);
    req[0] = 1'b0;
    wait_ack(0);
    chk("rd_rdata", rdata[0], 16'hBEEF);
    chk("rd_latency", ack_cyc[0] - acc_cyc[0], 2);
    chk("rd_oe_cycles", oe_lo[0], 2);
    @(negedge clk);

    // Full write A55A to the top address.
    issue(0, 1'b1, 18'h3FFFF, 16'hA55A, 2'b11);
    req[0] = 1'b0;
    wait_ack(0);
    chk("wr_latency", ack_cyc[0] - acc_cyc[0], 4);
    chk("wr_we_cycles", we_lo[0], 2);
    chk("wr_mem", pad_rd(key(0, 18'h3FFFF)), 16'hA55A);
    chk("wr_adr_hold", adr[0], 18'h3FFFF);
    @(negedge clk);

    // Upper-byte write over zero.
    preload(0, 18'h00000, 16'h0000);
    issue(0, 1'b1, 18'h00000, 16'h12FF, 2'b10);
    req[0] = 1'b0;
    wait_ack(0);
    chk("bw_mem", pad_rd(key(0, 18'h00000)), 16'h1200);
    chk("bw_be_n_or", be_or[0], 2'b01);
    chk("bw_be_n_and", be_and[0], 2'b01);
    chk("bw_cs_cycles", cs_lo[0], 4);
    @(negedge clk);

    // Write with no lanes enabled must still ack and leave memory alone.
    issue(0, 1'b1, 18'h00123, 16'h0000, 2'b00);
    req[0] = 1'b0;
    wait_ack(0);
    chk("be0_mem", pad_rd(key(0, 18'h00123)), 16'hBEEF);
    @(negedge clk);

    // Read followed immediately by write: one turnaround cycle before the write is taken.
    issue(0, 1'b0, 18'h00123, 16'h0000, 2'b00);
    issue(0, 1'b1, 18'h00055, 16'h7777, 2'b11);
    req[0] = 1'b0;
    chk("rw_rdata", rdata[0], 16'hBEEF);
    chk("rw_gap", acc_cyc[0] - ack_cyc[0], 2);
    wait_ack(0);
    @(negedge clk);
    issue(0, 1'b0, 18'h00055, 16'h0000, 2'b11);
    req[0] = 1'b0;
    wait_ack(0);
    chk("rw_readback", rdata[0], 16'h7777);
    @(negedge clk);

    // Reset while WE is low: strobes release at once and no ack follows.
    issue(0, 1'b1, 18'h00099, 16'h3C3C, 2'b11);
    req[0] = 1'b0;
    @(negedge clk);
    chk("pre_reset_we_n", we_n[0], 0);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_we_n", we_n[0], 1);
    chk("arst_cs_n", cs_n[0], 1);
    chk("arst_drive", drive[0], 0);
    chk("arst_ready", ready[0], 1);
    saved = ack_cnt[0];
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("arst_no_ack", ack_cnt[0], saved);

    // Random mix on the zero-wait instance.
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      issue(1, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 15)),
            16'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        req[1] = 1'b0;
        @(negedge clk);
      end
    end
    req[1] = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("rand_accepts", acc_cnt[1], 1000);
    chk("rand_acks", ack_cnt[1], acc_cnt[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
